// File: rtl/mult_seq_shiftadd.sv
// Iterative shift-add multiplier, STEP multiplier bits per cycle, valid/ready on both sides.
// Optional signed mode is compiled in with `define MULT_SIGNED_EN (adds the signed_op port).
module mult_seq_shiftadd #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
`ifdef MULT_SIGNED_EN
  input  logic               signed_op,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int N  = (STEP > 0) ? WIDTH / STEP : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_step
      $error("mult_seq_shiftadd: STEP must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              in_ready_q;
  logic [PW-1:0]     mcand_q;
  logic [WIDTH-1:0]  mplr_q;
  logic [PW-1:0]     acc_q;
  logic [CW-1:0]     cnt_q;
  logic [PW-1:0]     product_q;
  logic              neg_q;

  logic              accept, last;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic              neg_in;
  logic [PW-1:0]     pp, acc_sum, result;

  assign accept = in_valid & in_ready_q;
  assign last   = (cnt_q == LAST);

  // Signed mode multiplies magnitudes and fixes the sign once at the end.
`ifdef MULT_SIGNED_EN
  assign neg_in = signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
  assign a_mag  = (signed_op & A[WIDTH-1]) ? -A : A;
  assign b_mag  = (signed_op & B[WIDTH-1]) ? -B : B;
`else
  assign neg_in = 1'b0;
  assign a_mag  = A;
  assign b_mag  = B;
`endif

  // mcand_q is pre-shifted each cycle, so pp already carries the counter*STEP weight.
  assign pp      = mcand_q * {{(PW-STEP){1'b0}}, mplr_q[STEP-1:0]};
  assign acc_sum = acc_q + pp;
  assign result  = neg_q ? -acc_sum : acc_sum;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == S_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_BUSY;
      S_BUSY:  if (last)      state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      neg_q     <= 1'b0;
    end else if (accept) begin
      mcand_q <= {{WIDTH{1'b0}}, a_mag};
      mplr_q  <= b_mag;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= neg_in;
    end else if (state_q == S_BUSY) begin
      acc_q   <= acc_sum;
      mcand_q <= mcand_q << STEP;
      mplr_q  <= mplr_q >> STEP;
      cnt_q   <= cnt_q + CW'(1);
      if (last) product_q <= result;
    end
  end

  assign in_ready = in_ready_q;
  assign product  = product_q;

endmodule

// File: tb/tb_mult_seq_shiftadd.sv
// Self-checking bench: directed vector table, backpressure/reset sequences, and random ops
// against a plain-arithmetic reference on an 8x8 STEP=1 and a 16x16 STEP=4 instance.
module tb_mult_seq_shiftadd;

  localparam int W  = 8;
  localparam int S  = 1;
  localparam int N  = W / S;
  localparam int W2 = 16;
  localparam int S2 = 4;
  localparam int N2 = W2 / S2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           resetn, in_valid, in_ready, out_valid, out_ready, busy, signed_op;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] product;

  logic            v2_in_valid, v2_in_ready, v2_out_valid, v2_out_ready, v2_busy, v2_signed_op;
  logic [W2-1:0]   v2_a, v2_b;
  logic [2*W2-1:0] v2_product;

  int nerr = 0;
  int nchk = 0;

  mult_seq_shiftadd #(.WIDTH(W), .STEP(S)) u_dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b),
`ifdef MULT_SIGNED_EN
    .signed_op(signed_op),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  mult_seq_shiftadd #(.WIDTH(W2), .STEP(S2)) u_dut16 (
    .clk(clk), .resetn(resetn), .in_valid(v2_in_valid), .in_ready(v2_in_ready),
    .A(v2_a), .B(v2_b),
`ifdef MULT_SIGNED_EN
    .signed_op(v2_signed_op),
`endif
    .out_valid(v2_out_valid), .out_ready(v2_out_ready), .product(v2_product), .busy(v2_busy)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: integer product of the operands as numbers, truncated to 2w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input int w, input logic sgn);
    longint sx, sy, p;
    logic [63:0] mask;
    sx = longint'(x);
    sy = longint'(y);
    if (sgn && x[w-1]) sx = sx - (longint'(1) << w);
    if (sgn && y[w-1]) sy = sy - (longint'(1) << w);
    p = sx * sy;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic s, input string nm);
    int t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
    a = x; b = y; signed_op = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); signed_op = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 4 * N + 10) begin @(negedge clk); lat++; end
  endtask

  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic s,
                        input logic [15:0] exp, input string nm);
    int lat;
    start_op(x, y, s, nm);
    chk({nm, " busy"}, 64'(busy), 64'd1);
    wait_done(lat);
    chk({nm, " latency"}, 64'(lat), 64'(N));
    chk({nm, " product"}, 64'(product), 64'(exp));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " out_valid drop"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_op16(input logic [15:0] x, input logic [15:0] y, input string nm);
    int t = 0;
    int lat = 0;
    while (!v2_in_ready && t < 50) begin @(negedge clk); t++; end
    v2_a = x; v2_b = y; v2_signed_op = 1'b0; v2_in_valid = 1'b1;
    @(negedge clk);
    v2_in_valid = 1'b0;
    v2_a = 16'($urandom); v2_b = 16'($urandom);
    while (!v2_out_valid && lat < 4 * N2 + 10) begin @(negedge clk); lat++; end
    chk({nm, " latency"}, 64'(lat), 64'(N2));
    chk({nm, " product"}, 64'(v2_product), ref_mul(32'(x), 32'(y), W2, 1'b0));
    v2_out_ready = 1'b1;
    @(negedge clk);
    v2_out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bad;
    logic [7:0]  ra, rb;
    logic        rs;
    logic [15:0] rx, ry;

    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
    vecs.push_back('{8'h0B, 8'h05, 1'b0, 16'h0037});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 16'h00FF});
    vecs.push_back('{8'h01, 8'hFF, 1'b0, 16'h00FF});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 16'h0000});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 16'h4000});
    vecs.push_back('{8'hFF, 8'h80, 1'b0, 16'h7F80});
`ifdef MULT_SIGNED_EN
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001});
    vecs.push_back('{8'h80, 8'h7F, 1'b1, 16'hC080});
    vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
`endif

    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; signed_op = 1'b0;
    v2_in_valid = 1'b0; v2_out_ready = 1'b0; v2_a = '0; v2_b = '0; v2_signed_op = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset state", {60'd0, in_ready, out_valid, busy, 1'b0}, 64'd0);
    chk("reset product", 64'(product), 64'd0);
    resetn = 1'b1;
    #1 chk("in_ready before first edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("in_ready after first edge", 64'(in_ready), 64'd1);

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p, $sformatf("vec%0d", i));

    // Backpressure: result held, new requests ignored, then next op goes through.
    start_op(8'h3C, 8'h5A, 1'b0, "bp");
    wait_done(lat);
    chk("bp latency", 64'(lat), 64'(N));
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      chk($sformatf("bp hold %0d", i), {47'd0, out_valid, in_ready, product}, {47'd0, 1'b1, 1'b0, 16'h1518});
    end
    a = 8'h07; b = 8'h09; signed_op = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp release", {62'd0, out_valid, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat);
    chk("bp next latency", 64'(lat), 64'(N));
    chk("bp next product", 64'(product), 64'h003F);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset mid-operation: prior nonzero product must be cleared, no late result.
    run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "pre_rst");
    start_op(8'hAA, 8'h55, 1'b0, "rst_op");
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1 chk("mid reset state", {44'd0, out_valid, busy, in_ready, 1'b0, product}, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    out_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid || busy || product != 16'h0) bad++;
    end
    out_ready = 1'b0;
    chk("no stale result after reset", 64'(bad), 64'd0);
    chk("in_ready after reset", 64'(in_ready), 64'd1);
    run_op(8'h0B, 8'h05, 1'b0, 16'h0037, "post_rst");

    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
`ifdef MULT_SIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rs, 16'(ref_mul(32'(ra), 32'(rb), W, rs)), $sformatf("rnd%0d", i));
    end

    for (int i = 0; i < 150; i++) begin
      rx = 16'($urandom); ry = 16'($urandom);
      if (i == 0) begin rx = 16'hFFFF; ry = 16'hFFFF; end
      run_op16(rx, ry, $sformatf("w16_%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
